// File: rtl/task_6_pkg.sv
// task_6_pkg: shared types and constants for the task 6 output stage.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
//
// Contents:
//   state_t           output stage FSM states (S_IDLE, S_STREAM, S_DONE)
//   TASK6_*           default frame length, buffer depth and word width
//   ptr_width()       index width for a table of n entries (at least 1 bit)
package task_6_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam int TASK6_DATA_WIDTH = 8;
  localparam int TASK6_NUM_WORDS  = 243;
  localparam int TASK6_BUF_DEPTH  = 256;

  // Bits needed to index n entries; a single entry still gets one bit so
  // no vector ends up zero-width.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/task_6_out_buf.sv
// task_6_out_buf: ring buffer between the upstream word strobe and the output register.
// Latency: one cycle from i_rd_en to o_dout.
// Backpressure: none on the write side; writes while full are dropped and flagged on o_drop.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_wr_en, i_din      write strobe and word
//   i_rd_en, o_dout     fetch the oldest unfetched word into o_dout (held until next fetch)
//   i_rel               the fetched word has been consumed downstream; free its slot
//   o_full, o_empty     full = every slot occupied; empty = nothing left to fetch
//   o_count             occupied slots, including a fetched but not yet released word
//   o_drop              combinational: this cycle's write is being dropped
module task_6_out_buf
  import task_6_pkg::*;
#(
  parameter int DATA_WIDTH = TASK6_DATA_WIDTH,
  parameter int BUF_DEPTH  = TASK6_BUF_DEPTH,
  localparam int AW = ptr_width(BUF_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_din,
  input  logic                  i_rd_en,
  input  logic                  i_rel,
  output logic [DATA_WIDTH-1:0] o_dout,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [CW-1:0]         o_count,
  output logic                  o_drop
);

  logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_held;
  logic [DATA_WIDTH-1:0] r_dout;

  logic w_full;
  logic w_empty;
  logic w_wr;
  logic w_rd;
  logic w_rel;

  // A fetched word keeps its slot until released, so the depth bounds every
  // word the stage owns, including the one sitting in the output register.
  assign w_full  = (r_count == CW'(BUF_DEPTH));
  assign w_empty = (r_count == {{(CW-1){1'b0}}, r_held});
  assign w_wr    = i_wr_en & ~w_full;
  assign w_rd    = i_rd_en & ~w_empty;
  assign w_rel   = i_rel & r_held;

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_held   <= 1'b0;
      r_dout   <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_dout   <= r_mem[r_rd_ptr];
      end
      case ({w_wr, w_rel})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_rd) begin
        r_held <= 1'b1;
      end else if (w_rel) begin
        r_held <= 1'b0;
      end
    end
  end

  assign o_dout  = r_dout;
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;
  assign o_drop  = i_wr_en & w_full;

endmodule

// File: rtl/task_6_out.sv
// task_6_out: buffers the task 6 word stream and re-emits it as framed valid/ready beats.
// Latency: i_enb at cycle N gives o_tvalid with that word at N+2 at the earliest; 1 beat/cycle sustained.
// Backpressure: i_tready stalls the output (beat held stable); input has none, words are dropped when full.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_data, i_enb           upstream word and its one-cycle write strobe
//   o_tdata, o_tvalid       output beat
//   i_tready                downstream ready
//   o_tlast                 last beat of each NUM_WORDS frame (qualified by o_tvalid)
//   o_output_last           one-cycle frame-done pulse back to the input stage
//   o_overflow              sticky: a word was dropped because the buffer was full
//   o_frame_cnt [15:0]      completed frames, wrapping; present only with TASK_6_OUT_FRAME_CNT_EN
module task_6_out
  import task_6_pkg::*;
#(
  parameter int DATA_WIDTH = TASK6_DATA_WIDTH,
  parameter int NUM_WORDS  = TASK6_NUM_WORDS,
  parameter int BUF_DEPTH  = TASK6_BUF_DEPTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_enb,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic                  o_tvalid,
  input  logic                  i_tready,
  output logic                  o_tlast,
  output logic                  o_output_last,
`ifdef TASK_6_OUT_FRAME_CNT_EN
  output logic [15:0]           o_frame_cnt,
`endif
  output logic                  o_overflow
);

  localparam int CNT_W = ptr_width(NUM_WORDS);
  localparam int BCW   = ptr_width(BUF_DEPTH) + 1;

  // Pointers wrap by natural overflow, so the depth must be a power of two
  // (and at least 2 so the pointer is not a degenerate single bit).
  if (BUF_DEPTH < NUM_WORDS || BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("task_6_out: BUF_DEPTH must be a power of two >= max(NUM_WORDS, 2)");
  end

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_tvalid;
  logic [CNT_W-1:0]      r_tx_cnt;
  logic                  r_overflow;

  logic [DATA_WIDTH-1:0] w_dout;
  logic                  w_full;
  logic                  w_empty;
  logic [BCW-1:0]        w_count;
  logic                  w_drop;
  logic                  w_accept;
  logic                  w_tlast;
  logic                  w_last_acc;
  logic                  w_load;
  logic                  w_output_last;
  logic                  w_unused;

  task_6_out_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_buf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wr_en (i_enb),
    .i_din   (i_data),
    .i_rd_en (w_load),
    .i_rel   (w_accept),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_drop  (w_drop)
  );

  // Occupancy is only needed inside the buffer for now.
  assign w_unused = ^{w_full, w_count};

  assign w_accept   = r_tvalid & i_tready;
  assign w_tlast    = r_tvalid & (r_tx_cnt == CNT_W'(NUM_WORDS - 1));
  assign w_last_acc = w_accept & w_tlast;

  // Refill the output register when it is empty or its beat leaves this
  // cycle. A departing tlast beat does not refill: the following cycle is
  // the frame-done gap, where no beat may be shown. The register refills
  // during that gap so the next frame starts straight after it.
  assign w_load = ~w_empty & (~r_tvalid | (w_accept & ~w_tlast));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tvalid <= 1'b0;
    end else if (w_load) begin
      r_tvalid <= 1'b1;
    end else if (w_accept) begin
      r_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_cnt <= '0;
    end else if (w_last_acc) begin
      r_tx_cnt <= '0;
    end else if (w_accept) begin
      r_tx_cnt <= r_tx_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_output_last = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_last_acc) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_output_last = 1'b1;
        w_state_nxt   = w_empty ? S_IDLE : S_STREAM;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef TASK_6_OUT_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_cnt <= '0;
    end else if (r_state == S_DONE) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign o_frame_cnt = r_frame_cnt;
`endif

  assign o_tdata       = w_dout;
  assign o_tvalid      = r_tvalid;
  assign o_tlast       = w_tlast;
  assign o_output_last = w_output_last;
  assign o_overflow    = r_overflow;

endmodule
